// File: rtl/calc_pkg.sv
// Shared types and constants for the switch-driven calculator:
// sequencer states, ALU op codes and progress-LED patterns.
package calc_pkg;

  // NONE is only ever used as the "no pending target" value.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HAVE_A = 3'd1,
    HAVE_B = 3'd2,
    RESULT = 3'd3,
    HOLD   = 3'd4,
    NONE   = 3'd5
  } state_t;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;

  localparam logic [3:0] LED_IDLE   = 4'b0001;
  localparam logic [3:0] LED_HAVE_A = 4'b0011;
  localparam logic [3:0] LED_HAVE_B = 4'b0111;
  localparam logic [3:0] LED_RESULT = 4'b1111;

  // LED pattern for a state; HOLD (or anything else) keeps the previous pattern.
  function automatic logic [3:0] led_pattern(input state_t s, input logic [3:0] prev);
    case (s)
      IDLE:    return LED_IDLE;
      HAVE_A:  return LED_HAVE_A;
      HAVE_B:  return LED_HAVE_B;
      RESULT:  return LED_RESULT;
      default: return prev;
    endcase
  endfunction

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU: add/sub with signed overflow, bitwise
// logic, NOT A and single-bit shifts. Unknown op codes give 0 with ovf set.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  // Evaluate the selected operation; overflow only applies to add/sub.
  always_comb begin
    sum    = a + b;
    diff   = a - b;
    result = '0;
    ovf    = 1'b0;
    case (int'(op))
      OP_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = {a[WIDTH-2:0], 1'b0};
      OP_SHR:  result = {1'b0, a[WIDTH-1:1]};
      default: begin
        result = '0;
        ovf    = 1'b1;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/calc_sequencer.sv
// Enter-driven operand/operation sequencer: A, B, op code, then a
// registered ALU result. Every press parks in HOLD until Enter drops,
// so one physical press advances exactly one step.
//
// Handshake: there is no valid/ready pair here; Enter is a level whose
// rising edge (against enter_q) is a press, and Result_valid is a
// one-cycle strobe that accompanies a freshly registered Result_q.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OPW      = 4,
  parameter int CHAIN_EN = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [OPW+WIDTH-1:0] Switchs,
  input  logic                 Enter,
  input  logic                 Clear,
  input  logic                 Chain,
  output logic [WIDTH-1:0]     A_q,
  output logic [WIDTH-1:0]     B_q,
  output logic [OPW-1:0]       Op_q,
  output logic [WIDTH-1:0]     Result_q,
  output logic                 Zero_q,
  output logic                 Ovf_q,
  output logic                 Result_valid,
  output logic                 Show_a,
  output logic                 Show_b,
  output logic                 Show_r,
  output logic [3:0]           Leds,
  output state_t               State_dbg
);

  state_t           state_q, state_d;
  state_t           target_q, target_d;
  logic             enter_q, enter_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic             result_valid_q, result_valid_d;
  logic [3:0]       leds_q, leds_d;

  logic             press;
  logic             chain_take;
  logic             release_now;
  logic [WIDTH-1:0] operand;
  logic [OPW-1:0]   op_field;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_ovf;

  assign operand     = Switchs[WIDTH-1:0];
  assign op_field    = Switchs[OPW+WIDTH-1:WIDTH];
  assign enter_d     = Enter;
  assign press       = Enter && !enter_q;
  assign chain_take  = (CHAIN_EN != 0) && Chain;
  assign release_now = (state_q == HOLD) && !Enter;

  calc_alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .zero   (alu_zero),
    .ovf    (alu_ovf)
  );

  // Enter history: reset loads the live level so a press held across reset is ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) enter_q <= Enter;
    else       enter_q <= enter_d;
  end

  // State register with its pending target and LED pattern.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= NONE;
      leds_q   <= LED_IDLE;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      leds_q   <= leds_d;
    end
  end

  // Next state: Clear wins, a press parks in HOLD, release enters the target.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (Clear) begin
      state_d  = IDLE;
      target_d = NONE;
    end else begin
      case (state_q)
        IDLE:   if (press) begin state_d = HOLD; target_d = HAVE_A; end
        HAVE_A: if (press) begin state_d = HOLD; target_d = HAVE_B; end
        HAVE_B: if (press) begin state_d = HOLD; target_d = RESULT; end
        RESULT: if (press) begin state_d = HOLD; target_d = HAVE_A; end
        HOLD: begin
          if (!Enter) begin
            state_d  = (target_q == NONE) ? IDLE : target_q;
            target_d = NONE;
          end
        end
        default: begin
          state_d  = IDLE;
          target_d = NONE;
        end
      endcase
    end
  end

  // Outputs: display strobes follow the settled state; LEDs freeze through HOLD.
  always_comb begin
    Show_a = (state_q == HAVE_A) || (state_q == HAVE_B);
    Show_b = (state_q == HAVE_B);
    Show_r = (state_q == RESULT);
    leds_d = led_pattern(state_d, leds_q);
  end

  // Datapath registers: operands, op code, result and flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      result_q       <= '0;
      zero_q         <= 1'b0;
      ovf_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      result_q       <= result_d;
      zero_q         <= zero_d;
      ovf_q          <= ovf_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Capture on a press outside HOLD; latch the ALU on the release into RESULT.
  always_comb begin
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    result_d       = result_q;
    zero_d         = zero_q;
    ovf_d          = ovf_q;
    result_valid_d = 1'b0;
    if (Clear) begin
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      result_d = '0;
      zero_d   = 1'b0;
      ovf_d    = 1'b0;
    end else if (press && state_q != HOLD) begin
      case (state_q)
        IDLE:    a_d  = operand;
        HAVE_A:  b_d  = operand;
        HAVE_B:  op_d = op_field;
        RESULT:  a_d  = chain_take ? result_q : operand;
        default: a_d  = a_q;
      endcase
    end else if (release_now && target_q == RESULT) begin
      result_d       = alu_result;
      zero_d         = alu_zero;
      ovf_d          = alu_ovf;
      result_valid_d = 1'b1;
    end
  end

  assign A_q          = a_q;
  assign B_q          = b_q;
  assign Op_q         = op_q;
  assign Result_q     = result_q;
  assign Zero_q       = zero_q;
  assign Ovf_q        = ovf_q;
  assign Result_valid = result_valid_q;
  assign Leds         = leds_q;
  assign State_dbg    = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (WIDTH=8, OPW=4). Two instances share
// stimulus: one with chaining enabled, one with chaining disabled.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int WIDTH = 8;
  localparam int OPW   = 4;

  logic                 clock;
  logic                 reset;
  logic [OPW+WIDTH-1:0] switchs;
  logic                 enter;
  logic                 clear;
  logic                 chain;

  logic [WIDTH-1:0] a_q, b_q, result_q, a_nc, b_nc, result_nc;
  logic [OPW-1:0]   op_q, op_nc;
  logic             zero_q, ovf_q, valid, zero_nc, ovf_nc, valid_nc;
  logic             show_a, show_b, show_r, show_a_nc, show_b_nc, show_r_nc;
  logic [3:0]       leds, leds_nc;
  state_t           st, st_nc;

  int n_checks = 0;
  int n_pass   = 0;

  calc_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .CHAIN_EN(1)) dut (
    .clock(clock), .reset(reset), .Switchs(switchs), .Enter(enter),
    .Clear(clear), .Chain(chain), .A_q(a_q), .B_q(b_q), .Op_q(op_q),
    .Result_q(result_q), .Zero_q(zero_q), .Ovf_q(ovf_q),
    .Result_valid(valid), .Show_a(show_a), .Show_b(show_b),
    .Show_r(show_r), .Leds(leds), .State_dbg(st)
  );

  calc_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .CHAIN_EN(0)) dut_nc (
    .clock(clock), .reset(reset), .Switchs(switchs), .Enter(enter),
    .Clear(clear), .Chain(chain), .A_q(a_nc), .B_q(b_nc), .Op_q(op_nc),
    .Result_q(result_nc), .Zero_q(zero_nc), .Ovf_q(ovf_nc),
    .Result_valid(valid_nc), .Show_a(show_a_nc), .Show_b(show_b_nc),
    .Show_r(show_r_nc), .Leds(leds_nc), .State_dbg(st_nc)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single-cycle Enter pulse: press edge, then release edge.
  task automatic enter_value(input logic [3:0] op, input logic [7:0] v);
    switchs = {op, v};
    enter   = 1'b1;
    tick();
    enter   = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; clear = 1'b0; chain = 1'b0; switchs = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset values
    check_eq("rst_state", 32'(st), 32'(IDLE));
    check_eq("rst_leds", 32'(leds), 32'b0001);
    check_eq("rst_a", 32'(a_q), 0);
    check_eq("rst_result", 32'(result_q), 0);
    check_eq("rst_shows", {29'd0, show_a, show_b, show_r}, 0);
    check_eq("rst_valid", 32'(valid), 0);

    // 100 + 27: step-by-step checks including the 1-cycle HOLD
    switchs = {4'd0, 8'd100}; enter = 1'b1; tick();
    check_eq("hold_state", 32'(st), 32'(HOLD));
    check_eq("hold_a", 32'(a_q), 100);
    check_eq("hold_leds", 32'(leds), 32'b0001);
    enter = 1'b0; tick();
    check_eq("have_a_state", 32'(st), 32'(HAVE_A));
    check_eq("have_a_leds", 32'(leds), 32'b0011);
    check_eq("have_a_show", {29'd0, show_a, show_b, show_r}, 32'b100);
    enter_value(4'd0, 8'd27);
    check_eq("b_val", 32'(b_q), 27);
    check_eq("have_b_leds", 32'(leds), 32'b0111);
    check_eq("have_b_show", {29'd0, show_a, show_b, show_r}, 32'b110);
    enter_value(4'd0, 8'd0);
    check_eq("add_result", 32'(result_q), 127);
    check_eq("add_valid", 32'(valid), 1);
    check_eq("add_flags", {30'd0, zero_q, ovf_q}, 0);
    check_eq("res_leds", 32'(leds), 32'b1111);
    check_eq("res_show", {29'd0, show_a, show_b, show_r}, 32'b001);
    tick();
    check_eq("valid_pulse_end", 32'(valid), 0);

    // 100 + 28: signed overflow
    enter_value(4'd0, 8'd100);
    check_eq("fresh_a", 32'(a_q), 100);
    enter_value(4'd0, 8'd28);
    enter_value(4'd0, 8'd0);
    check_eq("ovf_result", 32'(result_q), 128);
    check_eq("ovf_flags", {30'd0, zero_q, ovf_q}, 32'b01);

    // 5 - 5: zero
    enter_value(4'd0, 8'd5);
    enter_value(4'd0, 8'd5);
    enter_value(4'd1, 8'd0);
    check_eq("sub_result", 32'(result_q), 0);
    check_eq("sub_flags", {30'd0, zero_q, ovf_q}, 32'b10);

    // Chain: 127 into A, then A<<1
    enter_value(4'd0, 8'd100);
    enter_value(4'd0, 8'd27);
    enter_value(4'd0, 8'd0);
    chain = 1'b1;
    enter_value(4'd0, 8'd3);
    chain = 1'b0;
    check_eq("chain_a", 32'(a_q), 127);
    check_eq("chain_state", 32'(st), 32'(HAVE_A));
    check_eq("chain_leds", 32'(leds), 32'b0011);
    check_eq("nochain_a", 32'(a_nc), 3);
    enter_value(4'd0, 8'd1);
    enter_value(4'd6, 8'd0);
    check_eq("chain_shl", 32'(result_q), 254);
    check_eq("nochain_shl", 32'(result_nc), 6);

    // Clear together with an Enter edge in HAVE_B
    enter_value(4'd0, 8'd10);
    enter_value(4'd0, 8'd20);
    check_eq("pre_clr_state", 32'(st), 32'(HAVE_B));
    switchs = {4'd3, 8'd0}; enter = 1'b1; clear = 1'b1; tick();
    check_eq("clr_edge_state", 32'(st), 32'(IDLE));
    check_eq("clr_edge_regs", {8'd0, a_q, b_q, 4'd0, op_q}, 0);
    check_eq("clr_edge_res", {22'd0, result_q, zero_q, ovf_q}, 0);
    check_eq("clr_edge_leds", 32'(leds), 32'b0001);
    clear = 1'b0; tick();
    check_eq("clr_held_nocap", {8'd0, a_q, 5'd0, st}, 0);
    enter = 1'b0; tick();

    // Clear while HOLD is waiting on a held Enter
    enter_value(4'd0, 8'd10);
    enter_value(4'd0, 8'd20);
    switchs = {4'd2, 8'd0}; enter = 1'b1; tick();
    check_eq("hold_op", 32'(op_q), 2);
    clear = 1'b1; tick();
    clear = 1'b0;
    check_eq("clr_hold_state", 32'(st), 32'(IDLE));
    check_eq("clr_hold_regs", {8'd0, a_q, b_q, 4'd0, op_q}, 0);
    enter = 1'b0; tick();
    check_eq("clr_hold_idle", 32'(st), 32'(IDLE));
    check_eq("clr_hold_valid", 32'(valid), 0);

    // Asynchronous reset mid-HOLD, Enter still high at release
    switchs = {4'd0, 8'd50}; enter = 1'b1; tick();
    check_eq("pre_rst_a", 32'(a_q), 50);
    reset = 1'b1; #1;
    check_eq("async_rst_state", 32'(st), 32'(IDLE));
    check_eq("async_rst_a", 32'(a_q), 0);
    check_eq("async_rst_leds", 32'(leds), 32'b0001);
    tick();
    reset = 1'b0;
    tick(); tick();
    check_eq("rst_held_state", 32'(st), 32'(IDLE));
    check_eq("rst_held_a", 32'(a_q), 0);
    enter = 1'b0; tick();

    // Unknown op code 12
    enter_value(4'd0, 8'd7);
    check_eq("post_rst_a", 32'(a_q), 7);
    enter_value(4'd0, 8'd9);
    enter_value(4'd12, 8'd0);
    check_eq("bad_op_result", 32'(result_q), 0);
    check_eq("bad_op_flags", {30'd0, zero_q, ovf_q}, 32'b11);
    check_eq("bad_op_valid", 32'(valid), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
